// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: widths, ALU operation codes,
// forward-select encoding and the per-source forwarding priority rule.
package mips_pkg;

   localparam int DATA_WIDTH     = 32;
   localparam int REG_ADDR_WIDTH = 5;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_NOR  = 4'b0010,
      ALU_ADD  = 4'b0011,
      ALU_SUB  = 4'b0100,
      ALU_XOR  = 4'b0101,
      ALU_WORD = 4'b0110,
      ALU_LUI  = 4'b1010
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_e;

   // MEM holds the younger producer, so it wins over WB; $0 is hardwired
   // to zero and must never pick up a forwarded value.
   function automatic fwd_sel_e fwd_select(
      input logic [REG_ADDR_WIDTH-1:0] src_addr,
      input logic                      mem_reg_write,
      input logic [REG_ADDR_WIDTH-1:0] mem_wb_addr,
      input logic                      wb_reg_write,
      input logic [REG_ADDR_WIDTH-1:0] wb_wb_addr
   );
      fwd_sel_e sel;
      sel = FWD_RF;
      if (src_addr != '0) begin
         if (mem_reg_write && (mem_wb_addr == src_addr))
            sel = FWD_MEM;
         else if (wb_reg_write && (wb_wb_addr == src_addr))
            sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle between the ID/MEM/WB side of the pipeline and the ID/EX operand
// stage. master = pipeline around the stage, slave = the stage itself.
interface id_ex_operand_stage_if;
   import mips_pkg::*;

   logic                      id_valid;
   logic [REG_ADDR_WIDTH-1:0] id_rs_addr;
   logic [REG_ADDR_WIDTH-1:0] id_rt_addr;
   logic                      id_uses_rt;
   logic [DATA_WIDTH-1:0]     id_read_data_1;
   logic [DATA_WIDTH-1:0]     id_read_data_2;
   logic [DATA_WIDTH-1:0]     id_imm_ext;
   logic                      id_alu_src;
   logic [3:0]                id_alu_operation;
   logic                      id_mem_read;
   logic                      id_mem_write;
   logic                      id_reg_write;
   logic [REG_ADDR_WIDTH-1:0] id_wb_addr;
   logic                      flush;
   logic                      mem_reg_write;
   logic [REG_ADDR_WIDTH-1:0] mem_wb_addr;
   logic [DATA_WIDTH-1:0]     mem_alu_result;
   logic                      wb_reg_write;
   logic [REG_ADDR_WIDTH-1:0] wb_wb_addr;
   logic [DATA_WIDTH-1:0]     wb_write_data;

   logic                      stall_id;
   logic                      ex_valid;
   logic [3:0]                alu_operation;
   logic [DATA_WIDTH-1:0]     alu_a;
   logic [DATA_WIDTH-1:0]     alu_b;
   logic [DATA_WIDTH-1:0]     ex_store_data;
   logic                      ex_mem_read;
   logic                      ex_mem_write;
   logic                      ex_reg_write;
   logic [REG_ADDR_WIDTH-1:0] ex_wb_addr;

   modport master (
      output id_valid, id_rs_addr, id_rt_addr, id_uses_rt, id_read_data_1,
             id_read_data_2, id_imm_ext, id_alu_src, id_alu_operation,
             id_mem_read, id_mem_write, id_reg_write, id_wb_addr, flush,
             mem_reg_write, mem_wb_addr, mem_alu_result,
             wb_reg_write, wb_wb_addr, wb_write_data,
      input  stall_id, ex_valid, alu_operation, alu_a, alu_b, ex_store_data,
             ex_mem_read, ex_mem_write, ex_reg_write, ex_wb_addr
   );

   modport slave (
      input  id_valid, id_rs_addr, id_rt_addr, id_uses_rt, id_read_data_1,
             id_read_data_2, id_imm_ext, id_alu_src, id_alu_operation,
             id_mem_read, id_mem_write, id_reg_write, id_wb_addr, flush,
             mem_reg_write, mem_wb_addr, mem_alu_result,
             wb_reg_write, wb_wb_addr, wb_write_data,
      output stall_id, ex_valid, alu_operation, alu_a, alu_b, ex_store_data,
             ex_mem_read, ex_mem_write, ex_reg_write, ex_wb_addr
   );

endinterface

// File: rtl/forwarding_unit.sv
// Combinational forward-select generation for the two EX source operands.
module forwarding_unit
   import mips_pkg::*;
(
   input  logic [REG_ADDR_WIDTH-1:0] i_ex_rs_addr,
   input  logic [REG_ADDR_WIDTH-1:0] i_ex_rt_addr,
   input  logic                      i_mem_reg_write,
   input  logic [REG_ADDR_WIDTH-1:0] i_mem_wb_addr,
   input  logic                      i_wb_reg_write,
   input  logic [REG_ADDR_WIDTH-1:0] i_wb_wb_addr,
   output fwd_sel_e                  o_fwd_rs,
   output fwd_sel_e                  o_fwd_rt
);

   // Same priority rule applied independently to rs and rt.
   always_comb begin
      o_fwd_rs = fwd_select(i_ex_rs_addr, i_mem_reg_write, i_mem_wb_addr,
                            i_wb_reg_write, i_wb_wb_addr);
      o_fwd_rt = fwd_select(i_ex_rt_addr, i_mem_reg_write, i_mem_wb_addr,
                            i_wb_reg_write, i_wb_wb_addr);
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register plus EX operand selection feeding the ALU.
// Build option ID_EX_FORWARDING_EN: when defined, RAW hazards are resolved
// by MEM/WB forwarding and only load-use stalls; when undefined, operands
// come from register-file data only and every EX/MEM RAW hazard stalls
// until the producer has reached WB (write-first register file).
module id_ex_operand_stage
   import mips_pkg::*;
(
   input logic                  clk,
   input logic                  reset,
   id_ex_operand_stage_if.slave bus
);

   logic                      r_ex_valid;
   logic [REG_ADDR_WIDTH-1:0] r_rs_addr;
   logic [REG_ADDR_WIDTH-1:0] r_rt_addr;
   logic [DATA_WIDTH-1:0]     r_read_data_1;
   logic [DATA_WIDTH-1:0]     r_read_data_2;
   logic [DATA_WIDTH-1:0]     r_imm_ext;
   logic                      r_alu_src;
   logic [3:0]                r_alu_operation;
   logic                      r_mem_read;
   logic                      r_mem_write;
   logic                      r_reg_write;
   logic [REG_ADDR_WIDTH-1:0] r_wb_addr;

   logic                  w_hazard;
   logic                  w_bubble;
   logic [DATA_WIDTH-1:0] w_rs_val;
   logic [DATA_WIDTH-1:0] w_rt_val;

   // True when a nonzero producer address is read by the instruction in ID.
   function automatic logic id_reads(input logic [REG_ADDR_WIDTH-1:0] addr);
      return (addr != '0) &&
             ((addr == bus.id_rs_addr) ||
              (bus.id_uses_rt && (addr == bus.id_rt_addr)));
   endfunction

`ifdef ID_EX_FORWARDING_EN
   fwd_sel_e w_fwd_rs;
   fwd_sel_e w_fwd_rt;

   forwarding_unit u_forwarding_unit (
      .i_ex_rs_addr    (r_rs_addr),
      .i_ex_rt_addr    (r_rt_addr),
      .i_mem_reg_write (bus.mem_reg_write),
      .i_mem_wb_addr   (bus.mem_wb_addr),
      .i_wb_reg_write  (bus.wb_reg_write),
      .i_wb_wb_addr    (bus.wb_wb_addr),
      .o_fwd_rs        (w_fwd_rs),
      .o_fwd_rt        (w_fwd_rt)
   );

   // Only a load in EX cannot be forwarded in time.
   assign w_hazard = bus.id_valid && r_ex_valid && r_mem_read &&
                     id_reads(r_wb_addr);

   // Operand muxes: registered RF data unless a younger producer matches.
   always_comb begin
      w_rs_val = r_read_data_1;
      w_rt_val = r_read_data_2;
      case (w_fwd_rs)
         FWD_MEM: w_rs_val = bus.mem_alu_result;
         FWD_WB:  w_rs_val = bus.wb_write_data;
         default: w_rs_val = r_read_data_1;
      endcase
      case (w_fwd_rt)
         FWD_MEM: w_rt_val = bus.mem_alu_result;
         FWD_WB:  w_rt_val = bus.wb_write_data;
         default: w_rt_val = r_read_data_2;
      endcase
   end
`else
   logic w_unused_nofwd;

   // Without forwarding, any producer still in EX or MEM blocks ID; once it
   // is in WB the write-first register file already returns the new value.
   assign w_hazard = bus.id_valid &&
                     ((r_ex_valid && r_reg_write && id_reads(r_wb_addr)) ||
                      (bus.mem_reg_write && id_reads(bus.mem_wb_addr)));

   assign w_unused_nofwd = ^{bus.mem_alu_result, bus.wb_reg_write,
                             bus.wb_wb_addr, bus.wb_write_data,
                             r_rs_addr, r_rt_addr};

   // Operands straight from the registered RF data.
   always_comb begin
      w_rs_val = r_read_data_1;
      w_rt_val = r_read_data_2;
   end
`endif

   assign w_bubble     = bus.flush | w_hazard;
   assign bus.stall_id = w_hazard & ~bus.flush;

   // ID/EX register: bubble on flush/hazard, otherwise capture ID.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ex_valid      <= 1'b0;
         r_rs_addr       <= '0;
         r_rt_addr       <= '0;
         r_read_data_1   <= '0;
         r_read_data_2   <= '0;
         r_imm_ext       <= '0;
         r_alu_src       <= 1'b0;
         r_alu_operation <= 4'b0000;
         r_mem_read      <= 1'b0;
         r_mem_write     <= 1'b0;
         r_reg_write     <= 1'b0;
         r_wb_addr       <= '0;
      end else if (w_bubble || !bus.id_valid) begin
         r_ex_valid      <= 1'b0;
         r_rs_addr       <= '0;
         r_rt_addr       <= '0;
         r_read_data_1   <= '0;
         r_read_data_2   <= '0;
         r_imm_ext       <= '0;
         r_alu_src       <= 1'b0;
         r_alu_operation <= 4'b0000;
         r_mem_read      <= 1'b0;
         r_mem_write     <= 1'b0;
         r_reg_write     <= 1'b0;
         r_wb_addr       <= '0;
      end else begin
         r_ex_valid      <= 1'b1;
         r_rs_addr       <= bus.id_rs_addr;
         r_rt_addr       <= bus.id_rt_addr;
         r_read_data_1   <= bus.id_read_data_1;
         r_read_data_2   <= bus.id_read_data_2;
         r_imm_ext       <= bus.id_imm_ext;
         r_alu_src       <= bus.id_alu_src;
         r_alu_operation <= bus.id_alu_operation;
         r_mem_read      <= bus.id_mem_read;
         r_mem_write     <= bus.id_mem_write;
         r_reg_write     <= bus.id_reg_write;
         r_wb_addr       <= bus.id_wb_addr;
      end
   end

   // Data outputs are held at zero while EX carries a bubble so forward
   // sources cannot leak into an idle ALU.
   always_comb begin
      bus.alu_a         = r_ex_valid ? w_rs_val : '0;
      bus.alu_b         = r_ex_valid ? (r_alu_src ? r_imm_ext : w_rt_val) : '0;
      bus.ex_store_data = r_ex_valid ? w_rt_val : '0;
   end

   assign bus.ex_valid      = r_ex_valid;
   assign bus.alu_operation = r_alu_operation;
   assign bus.ex_mem_read   = r_mem_read;
   assign bus.ex_mem_write  = r_mem_write;
   assign bus.ex_reg_write  = r_reg_write;
   assign bus.ex_wb_addr    = r_wb_addr;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage with an EX-stage reference model.
// Honours ID_EX_FORWARDING_EN the same way the design does.
module tb_id_ex_operand_stage;
   import mips_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   id_ex_operand_stage_if bus ();

   id_ex_operand_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

`ifdef ID_EX_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model of the instruction held in EX ----------
   typedef struct {
      bit        v;
      bit [4:0]  rs, rt;
      bit [31:0] d1, d2, imm;
      bit        src;
      bit [3:0]  op;
      bit        mr, mw, rw;
      bit [4:0]  wa;
   } ex_t;

   ex_t m;

   function automatic bit id_needs(input bit [4:0] a);
      return bus.id_valid && (a != 0) &&
             (a == bus.id_rs_addr || (bus.id_uses_rt && a == bus.id_rt_addr));
   endfunction

   function automatic bit exp_stall();
      bit h;
      if (FWD)
         h = m.v && m.mr && id_needs(m.wa);
      else
         h = (m.v && m.rw && id_needs(m.wa)) ||
             (bus.mem_reg_write && id_needs(bus.mem_wb_addr));
      return h && !bus.flush;
   endfunction

   function automatic bit [31:0] operand(input bit [4:0] a, input bit [31:0] rf);
      if (FWD && a != 0 && bus.mem_reg_write && bus.mem_wb_addr == a) return bus.mem_alu_result;
      if (FWD && a != 0 && bus.wb_reg_write && bus.wb_wb_addr == a) return bus.wb_write_data;
      return rf;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m = '{default: '0};
      end else if (bus.flush || exp_stall() || !bus.id_valid) begin
         m = '{default: '0};
      end else begin
         m.v   = 1'b1;
         m.rs  = bus.id_rs_addr;      m.rt = bus.id_rt_addr;
         m.d1  = bus.id_read_data_1;  m.d2 = bus.id_read_data_2;
         m.imm = bus.id_imm_ext;      m.src = bus.id_alu_src;
         m.op  = bus.id_alu_operation;
         m.mr  = bus.id_mem_read;     m.mw = bus.id_mem_write;
         m.rw  = bus.id_reg_write;    m.wa = bus.id_wb_addr;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("m_stall",    bus.stall_id,      exp_stall());
         chk("m_ex_valid", bus.ex_valid,      m.v);
         chk("m_alu_op",   bus.alu_operation, m.op);
         chk("m_alu_a",    bus.alu_a,         m.v ? operand(m.rs, m.d1) : 0);
         chk("m_alu_b",    bus.alu_b,         m.v ? (m.src ? m.imm : operand(m.rt, m.d2)) : 0);
         chk("m_store",    bus.ex_store_data, m.v ? operand(m.rt, m.d2) : 0);
         chk("m_ctrl",     {bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write}, {m.mr, m.mw, m.rw});
         chk("m_wb_addr",  bus.ex_wb_addr,    m.wa);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic id_idle();
      bus.id_valid = 0; bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_uses_rt = 0;
      bus.id_read_data_1 = 0; bus.id_read_data_2 = 0; bus.id_imm_ext = 0;
      bus.id_alu_src = 0; bus.id_alu_operation = 0; bus.id_mem_read = 0;
      bus.id_mem_write = 0; bus.id_reg_write = 0; bus.id_wb_addr = 0;
   endtask

   task automatic id_instr(input bit [4:0] rs, input bit [4:0] rt, input bit urt,
                           input bit [31:0] d1, input bit [31:0] d2, input bit [31:0] imm,
                           input bit src, input bit [3:0] op,
                           input bit mr, input bit mw, input bit rw, input bit [4:0] wa);
      bus.id_valid = 1; bus.id_rs_addr = rs; bus.id_rt_addr = rt; bus.id_uses_rt = urt;
      bus.id_read_data_1 = d1; bus.id_read_data_2 = d2; bus.id_imm_ext = imm;
      bus.id_alu_src = src; bus.id_alu_operation = op; bus.id_mem_read = mr;
      bus.id_mem_write = mw; bus.id_reg_write = rw; bus.id_wb_addr = wa;
   endtask

   task automatic set_mem(input bit rw, input bit [4:0] a, input bit [31:0] d);
      bus.mem_reg_write = rw; bus.mem_wb_addr = a; bus.mem_alu_result = d;
   endtask

   task automatic set_wb(input bit rw, input bit [4:0] a, input bit [31:0] d);
      bus.wb_reg_write = rw; bus.wb_wb_addr = a; bus.wb_write_data = d;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b1;
      id_idle();
      bus.flush = 0;
      set_mem(0, 0, 0);
      set_wb(0, 0, 0);
      #2;
      chk("rst_ex_valid", bus.ex_valid, 0);
      chk("rst_alu_op",   bus.alu_operation, 0);
      chk("rst_alu_a",    bus.alu_a, 0);
      chk("rst_stall",    bus.stall_id, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // ADD $3,$1,$2 with no hazards
      id_instr(1, 2, 1, 32'd5, 32'd7, 0, 0, ALU_ADD, 0, 0, 1, 3);
      tick();
      id_idle();
      @(negedge clk);
      chk("add_op", bus.alu_operation, 4'b0011);
      chk("add_a",  bus.alu_a, 5);
      chk("add_b",  bus.alu_b, 7);
      chk("add_wb", bus.ex_wb_addr, 3);

      // MEM vs WB priority on $4, alu_src selects immediate
      id_instr(4, 4, 1, 32'h99, 32'h55, 32'hABCD, 1, ALU_OR, 0, 0, 1, 8);
      tick();
      id_idle();
      set_mem(1, 4, 32'h10);
      set_wb(1, 4, 32'h20);
      @(negedge clk);
      chk("prio_a",     bus.alu_a, FWD ? 32'h10 : 32'h99);
      chk("prio_b_imm", bus.alu_b, 32'hABCD);
      chk("prio_store", bus.ex_store_data, FWD ? 32'h10 : 32'h55);
      set_mem(0, 0, 0);
      #1;
      chk("wb_only_a",  bus.alu_a, FWD ? 32'h20 : 32'h99);

      // Same with source $0: never forwarded
      set_wb(0, 0, 0);
      id_instr(0, 0, 1, 32'h77, 32'h66, 0, 0, ALU_ADD, 0, 0, 0, 0);
      tick();
      id_idle();
      set_mem(1, 0, 32'h10);
      set_wb(1, 0, 32'h20);
      @(negedge clk);
      chk("r0_a", bus.alu_a, 32'h77);
      chk("r0_b", bus.alu_b, 32'h66);

      // Load-use: LW $5 in EX, ADD $6,$5,$1 in ID
      set_mem(0, 0, 0);
      set_wb(0, 0, 0);
      id_instr(1, 0, 0, 32'h100, 0, 4, 1, ALU_ADD, 1, 0, 1, 5);
      tick();
      id_instr(5, 1, 1, 32'hDEAD, 32'd3, 0, 0, ALU_ADD, 0, 0, 1, 6);
      @(negedge clk);
      chk("lu_stall", bus.stall_id, 1);
      tick();
      set_mem(1, 5, 32'h104);
      @(negedge clk);
      chk("lu_bubble", bus.ex_valid, 0);
      chk("lu_stall2", bus.stall_id, FWD ? 0 : 1);
      if (FWD) begin
         tick();
         set_mem(0, 0, 0);
         set_wb(1, 5, 32'hCAFE);
         id_idle();
      end else begin
         tick();
         set_mem(0, 0, 0);
         set_wb(1, 5, 32'hCAFE);
         bus.id_read_data_1 = 32'hCAFE;
         @(negedge clk);
         chk("lu_release", bus.stall_id, 0);
         tick();
         set_wb(0, 0, 0);
         id_idle();
      end
      @(negedge clk);
      chk("lu_valid", bus.ex_valid, 1);
      chk("lu_a",     bus.alu_a, 32'hCAFE);
      chk("lu_b",     bus.alu_b, 3);

      // Load-use together with flush: flush wins
      set_wb(0, 0, 0);
      id_instr(0, 0, 0, 0, 0, 8, 1, ALU_ADD, 1, 0, 1, 7);
      tick();
      id_instr(7, 0, 0, 32'h1, 0, 0, 0, ALU_ADD, 0, 0, 1, 9);
      bus.flush = 1;
      @(negedge clk);
      chk("fl_stall", bus.stall_id, 0);
      tick();
      bus.flush = 0;
      id_idle();
      @(negedge clk);
      chk("fl_bubble", bus.ex_valid, 0);
      chk("fl_rw",     bus.ex_reg_write, 0);

      // ADD $2 in EX, SUB reads $2
      id_instr(1, 0, 0, 32'h40, 0, 2, 1, ALU_ADD, 0, 0, 1, 2);
      tick();
      id_instr(2, 0, 0, 32'h11, 0, 0, 0, ALU_SUB, 0, 0, 1, 9);
      @(negedge clk);
      chk("raw_stall1", bus.stall_id, FWD ? 0 : 1);
      if (FWD) begin
         tick();
         set_mem(1, 2, 32'h42);
         id_idle();
      end else begin
         tick();
         set_mem(1, 2, 32'h42);
         @(negedge clk);
         chk("raw_stall2", bus.stall_id, 1);
         chk("raw_bubble", bus.ex_valid, 0);
         tick();
         set_mem(0, 0, 0);
         set_wb(1, 2, 32'h42);
         bus.id_read_data_1 = 32'h42;
         @(negedge clk);
         chk("raw_release", bus.stall_id, 0);
         tick();
         set_wb(0, 0, 0);
         id_idle();
      end
      @(negedge clk);
      chk("raw_op", bus.alu_operation, 4'b0100);
      chk("raw_a",  bus.alu_a, 32'h42);

      // Asynchronous reset while EX is valid
      chk("pre_rst_valid", bus.ex_valid, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid", bus.ex_valid, 0);
      chk("arst_a",     bus.alu_a, 0);
      chk("arst_b",     bus.alu_b, 0);
      chk("arst_stall", bus.stall_id, 0);
      set_mem(0, 0, 0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      tick();
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
